// File: rtl/rf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rf_pkg                                                     |
// | Brief   : Shared widths and the write-back request type.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package rf_pkg;

  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

endpackage : rf_pkg
`default_nettype wire

// File: rtl/rf_wb_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rf_wb_fifo                                                 |
// | Brief   : Synchronous FIFO of write-back requests with full/empty.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rf_wb_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  wb_req_t                      push_data,
  input  logic                         pop,
  output wb_req_t                      pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  wb_req_t         r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_push;
  logic            w_pop;

  assign full     = (r_count == CW'(DEPTH));
  assign empty    = (r_count == '0);
  assign count    = r_count;
  assign pop_data = r_mem[r_rd_ptr];
  assign w_push   = push && !full;
  assign w_pop    = pop && !empty;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule : rf_wb_fifo
`default_nettype wire

// File: rtl/rf_writeback.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rf_writeback                                               |
// | Brief   : ALU/LSU write-port arbiter with pending-write scoreboard.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rf_writeback
  import rf_pkg::*;
#(
  parameter int XLEN      = rf_pkg::XLEN,
  parameter int NREG      = rf_pkg::NREG,
  parameter int LSU_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rd,
  output logic [NREG-1:0] busy,
  output logic            rf_we,
  output logic [4:0]      rf_rc,
  output logic [XLEN-1:0] rf_wd
);

  localparam int CW = $clog2(LSU_DEPTH + 1);

  wb_req_t          w_lsu_req;
  wb_req_t          w_fifo_head;
  wb_req_t          w_sel;
  logic             w_sel_valid;
  logic             w_sel_wr;
  logic             w_fifo_pop;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [CW-1:0]    w_unused_count;
  logic [NREG-1:0]  w_busy_nxt;
  logic [NREG-1:0]  r_busy;

  assign w_lsu_req.rd   = lsu_rd;
  assign w_lsu_req.data = lsu_data;

  rf_wb_fifo #(
    .DEPTH (LSU_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (lsu_valid),
    .push_data (w_lsu_req),
    .pop       (w_fifo_pop),
    .pop_data  (w_fifo_head),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty),
    .count     (w_unused_count)
  );

  // A full FIFO stalls the ALU so queued loads always make progress.
  assign lsu_ready = !w_fifo_full;
  assign alu_ready = !w_fifo_full;

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel       = '0;
    w_fifo_pop  = 1'b0;
    if (w_fifo_full) begin
      w_sel_valid = 1'b1;
      w_sel       = w_fifo_head;
      w_fifo_pop  = 1'b1;
    end else if (alu_valid) begin
      w_sel_valid = 1'b1;
      w_sel.rd    = alu_rd;
      w_sel.data  = alu_data;
    end else if (!w_fifo_empty) begin
      w_sel_valid = 1'b1;
      w_sel       = w_fifo_head;
      w_fifo_pop  = 1'b1;
    end
  end

  assign w_sel_wr = w_sel_valid && (w_sel.rd != '0);

  // A new issue to the register being retired keeps it pending.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_sel_wr)                   w_busy_nxt[w_sel.rd] = 1'b0;
    if (iss_valid && iss_rd != '0)  w_busy_nxt[iss_rd]   = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
      rf_we  <= 1'b0;
      rf_rc  <= '0;
      rf_wd  <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      rf_we  <= w_sel_wr;
      if (w_sel_valid) begin
        rf_rc <= w_sel.rd;
        rf_wd <= w_sel.data;
      end
    end
  end

  assign busy = r_busy;

endmodule : rf_writeback
`default_nettype wire

// File: tb/tb_rf_writeback.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_rf_writeback                                            |
// | Brief   : Directed bench for the register-file write-back block.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_rf_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [31:0] busy;
  logic        rf_we;
  logic [4:0]  rf_rc;
  logic [31:0] rf_wd;

  int checks   = 0;
  int failures = 0;

  rf_writeback dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .busy      (busy),
    .rf_we     (rf_we),
    .rf_rc     (rf_rc),
    .rf_wd     (rf_wd)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    alu_valid = 1'b0;
    alu_rd    = '0;
    alu_data  = '0;
    lsu_valid = 1'b0;
    lsu_rd    = '0;
    lsu_data  = '0;
    iss_valid = 1'b0;
    iss_rd    = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("reset_we",   rf_we, 0);
    chk("reset_rc",   rf_rc, 0);
    chk("reset_wd",   rf_wd, 0);
    chk("reset_busy", busy, 0);
    chk("reset_lrdy", lsu_ready, 1);
    chk("reset_ardy", alu_ready, 1);

    // ALU basic
    iss_valid = 1'b1; iss_rd = 5'd5;
    step();
    chk("alu_busy_set", busy, 32'h0000_0020);
    iss_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
    chk("alu_ready", alu_ready, 1);
    step();
    chk("alu_we",   rf_we, 1);
    chk("alu_rc",   rf_rc, 5);
    chk("alu_wd",   rf_wd, 32'hDEAD_BEEF);
    chk("alu_busy", busy, 0);
    alu_valid = 1'b0;
    step();
    chk("alu_idle_we", rf_we, 0);

    // x0 write is consumed without a register-file write
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
    chk("x0_ready", alu_ready, 1);
    step();
    chk("x0_we",   rf_we, 0);
    chk("x0_busy", busy, 0);
    alu_valid = 1'b0;

    // Set/clear collision on x7
    iss_valid = 1'b1; iss_rd = 5'd7;
    step();
    chk("col_busy_pre", busy, 32'h0000_0080);
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
    step();
    chk("col_we",   rf_we, 1);
    chk("col_rc",   rf_rc, 7);
    chk("col_wd",   rf_wd, 32'h77);
    chk("col_busy", busy, 32'h0000_0080);
    iss_valid = 1'b0; alu_data = 32'h78;
    step();
    chk("col_wd2",   rf_wd, 32'h78);
    chk("col_busy2", busy, 0);
    alu_valid = 1'b0;

    // Arbitration: ALU and LSU competing, FIFO fills and drains in order
    alu_rd = 5'd1; lsu_rd = 5'd2;
    alu_valid = 1'b1; alu_data = 32'hA0; lsu_valid = 1'b1; lsu_data = 32'h11;
    chk("arb0_ardy", alu_ready, 1);
    step();
    chk("arb0_wd", rf_wd, 32'hA0);
    chk("arb0_rc", rf_rc, 1);
    alu_data = 32'hA1; lsu_data = 32'h22;
    chk("arb1_lrdy", lsu_ready, 1);
    step();
    chk("arb1_wd", rf_wd, 32'hA1);
    alu_data = 32'hA2; lsu_data = 32'h33;
    chk("arb2_ardy", alu_ready, 0);
    chk("arb2_lrdy", lsu_ready, 0);
    step();
    chk("arb2_wd", rf_wd, 32'h11);
    chk("arb2_rc", rf_rc, 2);
    chk("arb3_ardy", alu_ready, 1);
    step();
    chk("arb3_wd", rf_wd, 32'hA2);
    alu_data = 32'hA3; lsu_valid = 1'b0;
    chk("arb4_ardy", alu_ready, 0);
    step();
    chk("arb4_wd", rf_wd, 32'h22);
    step();
    chk("arb5_wd", rf_wd, 32'hA3);
    chk("arb5_rc", rf_rc, 1);
    alu_valid = 1'b0;
    step();
    chk("arb6_wd", rf_wd, 32'h33);
    chk("arb6_rc", rf_rc, 2);
    chk("arb6_we", rf_we, 1);
    step();
    chk("arb7_we", rf_we, 0);

    // Reset mid-stream with two loads queued
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h300;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h41;
    iss_valid = 1'b1; iss_rd = 5'd9;
    step();
    lsu_data = 32'h42; iss_valid = 1'b0;
    step();
    chk("rst_pre_we",   rf_we, 1);
    chk("rst_pre_busy", busy, 32'h0000_0200);
    chk("rst_pre_full", lsu_ready, 0);
    alu_valid = 1'b0; lsu_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_we",   rf_we, 0);
    chk("rst_async_busy", busy, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_lrdy", lsu_ready, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst_no_write", rf_we, 0);
    end

    // FIFO wrap: ten back-to-back loads
    lsu_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      lsu_rd   = 5'(10 + i);
      lsu_data = 32'h1000 + 32'(i);
      chk("wrap_lrdy", lsu_ready, 1);
      step();
      if (i == 0) begin
        chk("wrap_first_we", rf_we, 0);
      end else begin
        chk("wrap_we", rf_we, 1);
        chk("wrap_rc", rf_rc, 64'(10 + i - 1));
        chk("wrap_wd", rf_wd, 64'(32'h1000 + 32'(i - 1)));
      end
    end
    lsu_valid = 1'b0;
    step();
    chk("wrap_last_rc", rf_rc, 19);
    chk("wrap_last_wd", rf_wd, 32'h1009);
    step();
    chk("wrap_drained_we", rf_we, 0);
    chk("wrap_drained_rdy", lsu_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_rf_writeback
`default_nettype wire
